muldiv_unit: RTL and testbench
==============================

# muldiv_unit

- Parametrised iterative multiply/divide unit owning the HI/LO register pair.
- Successor to the single-cycle datapath's ALU path: handles the multi-cycle MULT/MULTU/DIV/DIVU operations so the datapath can widen to 64-bit MIPS III while keeping one shared engine.
- The core issues an operation with a one-cycle start pulse, stalls on `busy`, and reads results from `hi`/`lo`.

## Interface
Parameters:
- `XLEN`, 32: operand and result width; legal values 32 or 64.
- `CNTW`, $clog2(XLEN)+1: iteration counter width; derived, do not override.

Ports:
- `CLK` input 1: single clock; all state on rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `start` input 1: issue pulse; sampled only when `busy`=0.
- `op` input 2: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU; sampled with `start`.
- `src_a` input XLEN: multiplicand / dividend.
- `src_b` input XLEN: multiplier / divisor.
- `hi_we` input 1: MTHI write strobe.
- `lo_we` input 1: MTLO write strobe.
- `wdata` input XLEN: MTHI/MTLO data.
- `busy` output 1: operation in flight.
- `done` output 1: one-cycle pulse; `hi`/`lo` hold the new result.
- `hi` output XLEN: product upper half / remainder.
- `lo` output XLEN: product lower half / quotient.

## Operation
- States: IDLE, RUN, FIX. `busy`=1 in RUN and FIX.
- IDLE with `start`=1:
  - Latch `op`, |src_a| and |src_b|. Operands are treated as magnitudes for signed ops.
  - Latch result sign:
    - MULT: sign(a) XOR sign(b).
    - DIV: quotient sign as MULT; remainder sign = sign(a).
  - Clear the counter and go to RUN.
  - Exception: DIV/DIVU with `src_b`=0 goes directly to FIX.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring shift-subtract.
  - After XLEN steps go to FIX.
- FIX:
  - Apply two's-complement sign correction to the product, or to quotient and remainder separately.
  - Load `hi`/`lo`, pulse `done`, return to IDLE.
- Arithmetic is modulo 2^XLEN per half. Signed DIV of MIN by −1 gives `lo`=MIN, `hi`=0.
- Divide by zero (both DIV and DIVU): `lo`=all ones, `hi`=`src_a`.
- `hi_we`/`lo_we` take effect only in IDLE with `start`=0. They are dropped while busy or when coincident with `start`.
- `start` while busy is ignored; no queuing.
- `start` is accepted in the same cycle `done` is high (back-to-back issue).

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0. Reset mid-operation discards the operation; `hi`/`lo` return to 0.
- `start` sampled at edge E0: `busy`=1 after E0.
- Steps occur at E1..E_XLEN; the FIX→IDLE transition is at E_XLEN+1.
- After E_XLEN+1: `done`=1 for one cycle, `hi`/`lo` valid, `busy`=0.
- Latency is XLEN+1 edges.
- Divide by zero: FIX entered at E0, `done` after E1.
- `hi`/`lo` are stable except at the FIX edge and accepted MTHI/MTLO edges.

## Configuration
- Macro: `MULDIV_CANCEL_EN`.
- Defined:
  - Adds port `cancel`, input, width 1.
  - `cancel`=1 in RUN or FIX returns to IDLE at the next edge. `busy` drops, no `done`, `hi`/`lo` unchanged.
  - `cancel` coincident with `start` in IDLE: `start` is ignored.
  - Used for exception flush.
- Undefined: port absent; every accepted operation completes.

## Test plan
- XLEN=32, MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` high exactly 33 edges after the start edge; `busy` high 33 cycles.
- MULT −3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000 / −1 → `lo`=0x80000000, `hi`=0.
- DIVU 5 / 0 → `lo`=0xFFFFFFFF, `hi`=5, `done` one edge after the start edge.
- Control conditions (expected behaviour in parentheses):
  - Second `start` mid-run (ignored; first result intact).
  - `hi_we` with `wdata`=0x1234 while busy (dropped).
  - Same write in IDLE (`hi`=0x1234).
  - Back-to-back start on the `done` cycle (accepted).
- Async `RST` low at step 10: all outputs 0 immediately.
- With `MULDIV_CANCEL_EN`: `cancel` at step 5 gives `busy`=0 next edge, no `done`, `hi`/`lo` unchanged.
- XLEN=64: DMULTU 2^63 × 4 → `hi`=2, `lo`=0, latency 65 edges.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide engine that owns HI/LO.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle; signed operations run on magnitudes and fix the sign at the end.
// Optional macro MULDIV_CANCEL_EN adds a 'cancel' input that flushes an
// in-flight operation without touching HI/LO.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int CNTW = $clog2(XLEN) + 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
`ifdef MULDIV_CANCEL_EN
    input  logic            cancel,
`endif
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

    localparam logic [CNTW-1:0] LAST = CNTW'(XLEN - 1);

    state_e              state_q, state_d;
    logic [CNTW-1:0]     cnt_q;
    logic                is_div_q, neg_q, rneg_q, done_q;
    logic [XLEN-1:0]     dvs_q, hi_q, lo_q;
    logic [2*XLEN-1:0]   acc_q;

    logic                cancel_w;
`ifdef MULDIV_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    // Issue-side decode: signedness, magnitudes, divide-by-zero.
    logic            sgn, sa, sb, divz, accept;
    logic [XLEN-1:0] mag_a, mag_b;
    assign sgn    = ~op[0];
    assign sa     = sgn & src_a[XLEN-1];
    assign sb     = sgn & src_b[XLEN-1];
    assign mag_a  = sa ? -src_a : src_a;
    assign mag_b  = sb ? -src_b : src_b;
    assign divz   = op[1] & (src_b == '0);
    assign accept = (state_q == S_IDLE) & start & ~cancel_w;

    // Single radix-2 step for both operations.
    logic [XLEN:0]     mul_sum, div_r, div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] mul_nxt, div_nxt;
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    assign mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_r    = acc_q[2*XLEN-1:XLEN-1];
    assign div_ge   = div_r >= {1'b0, dvs_q};
    assign div_diff = div_r - {1'b0, dvs_q};
    assign div_rem  = div_ge ? div_diff[XLEN-1:0] : div_r[XLEN-1:0];
    assign div_nxt  = {div_rem, acc_q[XLEN-2:0], div_ge};

    // Final sign correction: whole product, or quotient/remainder separately.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, hi_fix, lo_fix;
    assign prod_fix = neg_q  ? -acc_q : acc_q;
    assign quo_fix  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    assign hi_fix   = is_div_q ? rem_fix : prod_fix[2*XLEN-1:XLEN];
    assign lo_fix   = is_div_q ? quo_fix : prod_fix[XLEN-1:0];

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; cancel flushes RUN/FIX straight back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = divz ? S_FIX : S_RUN;
            S_RUN:  if (cancel_w) state_d = S_IDLE;
                    else if (cnt_q == LAST) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy flag, step/result enables, MTHI/MTLO window.
    logic step_en, fix_ld, mt_ok;
    always_comb begin
        busy    = 1'b0;
        step_en = 1'b0;
        fix_ld  = 1'b0;
        mt_ok   = 1'b0;
        case (state_q)
            S_IDLE: mt_ok = ~start;
            S_RUN:  begin busy = 1'b1; step_en = ~cancel_w; end
            S_FIX:  begin busy = 1'b1; fix_ld  = ~cancel_w; end
            default: ;
        endcase
    end

    // Operand latch at issue and iterative accumulator update.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dvs_q    <= '0;
            acc_q    <= '0;
        end else if (accept) begin
            cnt_q    <= '0;
            is_div_q <= op[1];
            // Divide-by-zero bypasses the engine: park the raw result in acc.
            neg_q    <= divz ? 1'b0 : (sa ^ sb);
            rneg_q   <= divz ? 1'b0 : (op[1] & sa);
            dvs_q    <= op[1] ? mag_b : mag_a;
            if (divz)       acc_q <= {src_a, {XLEN{1'b1}}};
            else if (op[1]) acc_q <= {{XLEN{1'b0}}, mag_a};
            else            acc_q <= {{XLEN{1'b0}}, mag_b};
        end else if (step_en) begin
            cnt_q <= cnt_q + 1'b1;
            acc_q <= is_div_q ? div_nxt : mul_nxt;
        end
    end

    // HI/LO architectural registers and the done pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= fix_ld;
            if (fix_ld) begin
                hi_q <= hi_fix;
                lo_q <= lo_fix;
            end else begin
                if (mt_ok && hi_we) hi_q <= wdata;
                if (mt_ok && lo_we) lo_q <= wdata;
            end
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: scoreboard of expected HI/LO per issued op,
// latency/busy accounting, control corner cases, and a 64-bit instance.
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start, hi_we, lo_we, cancel;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata, hi, lo;
    logic        busy, done;

    logic        start64;
    logic [63:0] a64, b64, hi64, lo64;
    logic        busy64, done64;

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] sb[$];

    always #5 CLK = ~CLK;

    muldiv_unit #(.XLEN(32)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
`ifdef MULDIV_CANCEL_EN
        .cancel(cancel),
`endif
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.XLEN(64)) dut64 (
        .CLK(CLK), .RST(RST), .start(start64), .op(2'b01), .src_a(a64), .src_b(b64),
        .hi_we(1'b0), .lo_we(1'b0), .wdata(64'd0),
`ifdef MULDIV_CANCEL_EN
        .cancel(1'b0),
`endif
        .busy(busy64), .done(done64), .hi(hi64), .lo(lo64)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one op just after an edge; it is sampled at the next edge (E0).
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
        op = o; src_a = a; src_b = b; start = 1'b1;
        sb.push_back({64'd0, ehi, elo});
        @(posedge CLK); #1;
        start = 1'b0;
        chk("busy_after_start", 128'(busy), 128'(1));
    endtask

    // Wait for done; check latency, busy span and the scoreboard result.
    task automatic wait_done(input string tag, input int lat, input bit inject);
        int n = 0;
        int bc = 1;
        logic [127:0] e;
        while (done !== 1'b1 && n < 200) begin
            @(posedge CLK); #1;
            n++;
            if (busy === 1'b1) bc++;
            if (inject && n == 5) begin
                start = 1'b1; op = 2'b11; src_a = 32'd1; src_b = 32'd1;
                hi_we = 1'b1; wdata = 32'h1234;
            end else if (inject && n == 6) begin
                start = 1'b0; hi_we = 1'b0;
            end
        end
        start = 1'b0; hi_we = 1'b0;
        chk({tag, "_latency"}, 128'(n), 128'(lat));
        chk({tag, "_busy_cycles"}, 128'(bc), 128'(lat));
        if (sb.size() == 0) chk({tag, "_scoreboard_empty"}, 128'(0), 128'(1));
        else begin
            e = sb.pop_front();
            chk({tag, "_hilo"}, {64'd0, hi, lo}, e);
        end
    endtask

    initial begin
        RST = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; cancel = 1'b0;
        op = 2'b00; src_a = '0; src_b = '0; wdata = '0;
        start64 = 1'b0; a64 = '0; b64 = '0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1;
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_done", 128'(done), 128'(0));
        chk("reset_hilo", {64'd0, hi, lo}, 128'd0);

        // MULTU max*max with a spurious start + MTHI injected mid-run
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        wait_done("multu_max", 33, 1'b1);
        @(posedge CLK); #1;
        chk("done_one_cycle", 128'(done), 128'(0));
        chk("hilo_stable", {64'd0, hi, lo}, {64'd0, 32'hFFFFFFFE, 32'h00000001});

        issue(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        wait_done("mult_neg", 33, 1'b0);

        issue(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        wait_done("div_neg", 33, 1'b0);

        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        wait_done("div_min_m1", 33, 1'b0);

        issue(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
        wait_done("divu_zero", 1, 1'b0);

        issue(2'b10, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);
        wait_done("div_zero", 1, 1'b0);

        // Back-to-back: second issue driven in the done cycle
        issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        wait_done("divu_100_7", 33, 1'b0);
        issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42);
        wait_done("b2b_multu", 33, 1'b0);

        // MTHI / MTLO in IDLE
        hi_we = 1'b1; wdata = 32'h1234;
        @(posedge CLK); #1 hi_we = 1'b0;
        chk("mthi_idle", {64'd0, hi, lo}, {64'd0, 32'h1234, 32'd42});
        lo_we = 1'b1; wdata = 32'hABCD;
        @(posedge CLK); #1 lo_we = 1'b0;
        chk("mtlo_idle", {64'd0, hi, lo}, {64'd0, 32'h1234, 32'hABCD});

        // MTHI coincident with start is dropped
        hi_we = 1'b1; wdata = 32'hBEEF;
        issue(2'b01, 32'd2, 32'd3, 32'd0, 32'd6);
        hi_we = 1'b0;
        chk("mthi_with_start", 128'(hi), 128'(32'h1234));
        wait_done("multu_2_3", 33, 1'b0);

`ifdef MULDIV_CANCEL_EN
        issue(2'b01, 32'd9, 32'd9, 32'd0, 32'd81);
        repeat (5) @(posedge CLK);
        #1 cancel = 1'b1;
        @(posedge CLK); #1 cancel = 1'b0;
        void'(sb.pop_back());
        chk("cancel_busy", 128'(busy), 128'(0));
        chk("cancel_done", 128'(done), 128'(0));
        begin
            int seen = 0;
            repeat (40) begin
                @(posedge CLK); #1;
                if (done === 1'b1) seen++;
            end
            chk("cancel_no_done", 128'(seen), 128'(0));
        end
        chk("cancel_hilo", {64'd0, hi, lo}, {64'd0, 32'd0, 32'd6});
`endif

        // 64-bit DMULTU 2^63 * 4
        a64 = 64'h8000000000000000; b64 = 64'd4; start64 = 1'b1;
        @(posedge CLK); #1 start64 = 1'b0;
        begin
            int n = 0;
            while (done64 !== 1'b1 && n < 200) begin
                @(posedge CLK); #1;
                n++;
            end
            chk("dmultu_latency", 128'(n), 128'(65));
            chk("dmultu_hilo", {hi64, lo64}, {64'd2, 64'd0});
        end

        // Async reset mid-operation
        issue(2'b01, 32'd3, 32'd3, 32'd0, 32'd9);
        repeat (10) @(posedge CLK);
        #2 RST = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("rst_mid_busy", 128'(busy), 128'(0));
        chk("rst_mid_done", 128'(done), 128'(0));
        chk("rst_mid_hilo", {64'd0, hi, lo}, 128'd0);
        @(negedge CLK) RST = 1'b1;
        @(posedge CLK); #1;
        chk("rst_release_busy", 128'(busy), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
